dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port round-robin arbiter and access sequencer for the 128-bit single-port data memory (129 entries, synchronous write, combinational read). Port 0 (vector load/store unit) and port 1 (debug/DMA loader) share the memory. The block latches one request per access, drives the memory for exactly one cycle, and returns registered read data or an error pulse one cycle later. It sits between the requesters and the data memory and is the only driver of the memory's address, data, `we` and `re` inputs.

## Interface
- `ADDR_W`, 8, requester address width
- `DATA_W`, 128, data width
- `DEPTH`, 129, number of valid memory entries; addresses >= DEPTH are out of range
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `p0_req`, `p1_req`  in  1  access request; held until the matching gnt
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read
- `p0_addr`, `p1_addr`  in  ADDR_W  word address
- `p0_wdata`, `p1_wdata`  in  DATA_W  write data
- `p0_gnt`, `p1_gnt`  out  1  one-cycle pulse in the cycle the memory is driven for that port
- `p0_rvalid`, `p1_rvalid`  out  1  one-cycle pulse: read data valid
- `p0_rdata`, `p1_rdata`  out  DATA_W  registered read data; holds until the next read for that port
- `p0_err`, `p1_err`  out  1  one-cycle pulse: out-of-range access
- `mem_addr`  out  128  memory address, zero-extended from the latched ADDR_W address
- `mem_wdata`  out  128  memory write data
- `mem_we`, `mem_re`  out  1  memory write/read enables
- `mem_rdata`  in  128  memory combinational read data

## Operation
- FSM states:
  - IDLE: no access in flight.
  - BUSY: memory driven from the latched request.
- Arbitration runs at every clock edge in IDLE and in BUSY.
  - Eligible ports: those with `req`=1, excluding any port whose gnt=1 in the current cycle. That port's req is ignored for one cycle.
  - One eligible port: that port wins.
  - Two eligible ports: the port != `last_grant` wins.
  - Winner present: latch `we`, `addr`, `wdata` and the port id into request registers, set `last_grant`=winner, go to (or stay in) BUSY.
  - No winner: go to IDLE.
- BUSY cycle:
  - `pX_gnt`=1 for the latched port.
  - `mem_addr`/`mem_wdata` driven from the latch.
  - In range, write: `mem_we`=1, `mem_re`=0; write commits at the end of the cycle.
  - In range, read: `mem_re`=1; `mem_rdata` is captured into `pX_rdata` at the end of the cycle, and `pX_rvalid`=1 in the next cycle.
  - Out of range (addr >= DEPTH): `mem_we`=`mem_re`=0; `pX_err`=1 in the next cycle; no rvalid; rdata unchanged.
- Outside BUSY: `mem_we`=`mem_re`=0, and `mem_addr`/`mem_wdata` hold their last values.
- `mem_we` is forced to 0 combinationally whenever `rst`=0, so a memory clear never races a write.
- Requesters may change `req`/`addr`/`we`/`wdata` freely after seeing gnt, because the request is latched.

## Timing
- Reset (rst=0 at an edge):
  - State → IDLE; `last_grant` → 1, so port 0 wins the first contention.
  - All gnt, rvalid and err outputs → 0; both rdata → 0; request latch → 0.
  - `mem_addr`, `mem_wdata`, `mem_we`, `mem_re` → 0.
- Reset mid-BUSY: the in-flight access is dropped; no rvalid/err follows.
- Latency: req sampled at edge N → gnt in cycle N+1 → rvalid/err in cycle N+2.
- Throughput:
  - One access per cycle while both ports request.
  - A single port alone gets a grant every other cycle, because its req is ignored in its own gnt cycle.
- rvalid/err from access k and gnt of access k+1 may coincide in the same cycle.
- Write then read to the same address on consecutive grants returns the new data (write commits before the next BUSY cycle).

## Test plan
- Reset: hold rst=0 for 2 cycles with both req=1 → no gnt, all outputs 0. Release → first gnt on p0 (`last_grant`=1).
- Single read: preload mem[5]=128'hA5; p0 read addr 5 at edge N → p0_gnt=1, mem_re=1, mem_addr=5 in cycle N+1; p0_rvalid=1, p0_rdata=128'hA5 in cycle N+2.
- Contention: both ports keep req=1 with writes of 1 (p0) and 2 (p1) to addrs 10 and 11 → grants alternate p0, p1, p0, … on consecutive cycles; mem_we=1 each BUSY cycle; mem[10]=1, mem[11]=2.
- Write then read: p1 writes 128'hDEAD to addr 128 (last valid entry), then reads addr 128 → p1_rvalid with p1_rdata=128'hDEAD.
- Out of range: p0 read addr 129 → p0_gnt pulses with mem_we=mem_re=0; p0_err=1 next cycle; no p0_rvalid; p0_rdata unchanged.
- Reset mid-write: drive rst=0 in the BUSY cycle of a write to addr 3 → mem_we=0 in that cycle; mem[3]=0 after the clear; no rvalid/err afterwards.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and one-cycle access sequencer for the shared
// 128-bit data memory; latches a winning request, drives the memory, returns data/err.
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 129
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,

    output logic [127:0]      mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int MEM_AW = 128;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic              last_grant, last_grant_nxt;
    logic              elig0, elig1;
    logic              win_vld, win_port;

    logic              vld_p0;
    logic              port_p0;
    logic              we_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              hit_p0;
    logic              rd_fire_p0, err_fire_p0;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({{(32-ADDR_W){1'b0}}, a} < DEPTH[31:0]);
    endfunction

    // Arbitration: a port granted this cycle sits out, so its held req is not re-granted.
    always_comb begin
        elig0    = p0_req && !p0_gnt;
        elig1    = p1_req && !p1_gnt;
        win_vld  = elig0 || elig1;
        win_port = elig1;
        if (elig0 && elig1) begin
            win_port = ~last_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE, BUSY: begin
                if (win_vld) begin
                    state_nxt      = BUSY;
                    last_grant_nxt = win_port;
                end else begin
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: latched request, memory driven while BUSY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            port_p0  <= 1'b0;
            we_p0    <= 1'b0;
            addr_p0  <= '0;
            wdata_p0 <= '0;
        end else if (win_vld) begin
            port_p0  <= win_port;
            we_p0    <= win_port ? p1_we    : p0_we;
            addr_p0  <= win_port ? p1_addr  : p0_addr;
            wdata_p0 <= win_port ? p1_wdata : p0_wdata;
        end
    end

    assign vld_p0      = (state == BUSY);
    assign hit_p0      = in_range(addr_p0);
    assign rd_fire_p0  = vld_p0 && hit_p0 && !we_p0;
    assign err_fire_p0 = vld_p0 && !hit_p0;

    always_comb begin
        p0_gnt    = vld_p0 && !port_p0;
        p1_gnt    = vld_p0 &&  port_p0;
        mem_addr  = {{(MEM_AW-ADDR_W){1'b0}}, addr_p0};
        mem_wdata = wdata_p0;
        mem_we    = vld_p0 && hit_p0 && we_p0 && rst;
        mem_re    = rd_fire_p0;
    end

    // Stage p1: registered read data and response pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p1_err    <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= rd_fire_p0  && !port_p0;
            p1_rvalid <= rd_fire_p0  &&  port_p0;
            p0_err    <= err_fire_p0 && !port_p0;
            p1_err    <= err_fire_p0 &&  port_p0;
            if (rd_fire_p0 && !port_p0) begin
                p0_rdata <= mem_rdata;
            end
            if (rd_fire_p0 && port_p0) begin
                p1_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed reset/contention/corner sequences, a vector
// table of single accesses, and a randomized run against a transaction-level model.
module tb_dmem_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         rq    [2];
    logic         rwe   [2];
    logic [7:0]   raddr [2];
    logic [127:0] rwd   [2];

    logic         p0_req, p1_req, p0_we, p1_we;
    logic [7:0]   p0_addr, p1_addr;
    logic [127:0] p0_wdata, p1_wdata;
    logic         p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
    logic [127:0] p0_rdata, p1_rdata;
    logic [127:0] mem_addr, mem_wdata, mem_rdata;
    logic         mem_we, mem_re;

    logic [127:0] mem [0:128];
    logic         pre_en = 1'b0;
    logic [7:0]   pre_addr = '0;
    logic [127:0] pre_data = '0;

    int checks = 0;
    int errors = 0;

    assign p0_req = rq[0];  assign p1_req = rq[1];
    assign p0_we  = rwe[0]; assign p1_we  = rwe[1];
    assign p0_addr = raddr[0]; assign p1_addr = raddr[1];
    assign p0_wdata = rwd[0];  assign p1_wdata = rwd[1];

    dmem_arbiter #(.ADDR_W(8), .DATA_W(128), .DEPTH(129)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: clear on reset, but a write in the same edge survives the clear.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 129; i++) mem[i] <= '0;
        end else if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end
        if (mem_we && mem_addr < 128'd129) mem[mem_addr[7:0]] <= mem_wdata;
    end
    assign mem_rdata = (mem_addr < 128'd129) ? mem[mem_addr[7:0]] : '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    typedef struct {
        int           port;
        bit           we;
        logic [7:0]   addr;
        logic [127:0] wdata;
        bit           exp_rv;
        bit           exp_err;
        logic [127:0] exp_rd;
    } vec_t;

    vec_t         tbl [11];
    logic [127:0] exp_rd [2];

    function automatic logic gnt_of(input int p);
        return (p == 0) ? p0_gnt : p1_gnt;
    endfunction
    function automatic logic rv_of(input int p);
        return (p == 0) ? p0_rvalid : p1_rvalid;
    endfunction
    function automatic logic err_of(input int p);
        return (p == 0) ? p0_err : p1_err;
    endfunction
    function automatic logic [127:0] rd_of(input int p);
        return (p == 0) ? p0_rdata : p1_rdata;
    endfunction

    task automatic access(input vec_t v);
        int lat;
        bit hit;
        hit = (v.addr < 8'd129) ? 1'b1 : 1'b0;
        @(negedge clk);
        rq[v.port] = 1'b1; rwe[v.port] = v.we; raddr[v.port] = v.addr; rwd[v.port] = v.wdata;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!gnt_of(v.port) && lat < 4);
        rq[v.port] = 1'b0;
        chk("acc_latency", lat, 1);
        chk("acc_other_gnt", gnt_of(1 - v.port), 0);
        chk("acc_mem_we", mem_we, v.we && hit);
        chk("acc_mem_re", mem_re, !v.we && hit);
        chk("acc_mem_addr", mem_addr, {120'd0, v.addr});
        if (v.we) chk("acc_mem_wdata", mem_wdata, v.wdata);
        if (v.exp_rv) exp_rd[v.port] = v.exp_rd;
        @(negedge clk);
        chk("acc_rvalid", rv_of(v.port), v.exp_rv);
        chk("acc_err", err_of(v.port), v.exp_err);
        chk("acc_rdata", rd_of(v.port), exp_rd[v.port]);
        @(negedge clk);
        chk("acc_pulse_end", {rv_of(v.port), err_of(v.port), gnt_of(v.port)}, 0);
    endtask

    // Transaction-level reference for the randomized run.
    bit           m_busy;
    int           m_port, m_last;
    bit           m_we;
    logic [7:0]   m_addr;
    logic [127:0] m_wdata;
    bit           m_rv [2];
    bit           m_err [2];
    logic [127:0] m_rdata [2];
    logic [127:0] ref_mem [0:128];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0; rwe[p] = 1'b0; raddr[p] = '0; rwd[p] = '0; exp_rd[p] = '0;
        end

        tbl[0]  = '{0, 1'b0, 8'd5,   128'h0,      1'b1, 1'b0, 128'hA5};
        tbl[1]  = '{1, 1'b1, 8'd128, 128'hDEAD,   1'b0, 1'b0, 128'h0};
        tbl[2]  = '{1, 1'b0, 8'd128, 128'h0,      1'b1, 1'b0, 128'hDEAD};
        tbl[3]  = '{0, 1'b0, 8'd129, 128'h0,      1'b0, 1'b1, 128'h0};
        tbl[4]  = '{1, 1'b0, 8'd255, 128'h0,      1'b0, 1'b1, 128'h0};
        tbl[5]  = '{0, 1'b1, 8'd0,   128'h1111,   1'b0, 1'b0, 128'h0};
        tbl[6]  = '{0, 1'b0, 8'd0,   128'h0,      1'b1, 1'b0, 128'h1111};
        tbl[7]  = '{1, 1'b0, 8'd5,   128'h0,      1'b1, 1'b0, 128'hA5};
        tbl[8]  = '{0, 1'b1, 8'd128, 128'hBEEF,   1'b0, 1'b0, 128'h0};
        tbl[9]  = '{1, 1'b0, 8'd128, 128'h0,      1'b1, 1'b0, 128'hBEEF};
        tbl[10] = '{1, 1'b1, 8'd129, 128'h7777,   1'b0, 1'b1, 128'h0};

        // Reset with both ports requesting, then contention with alternating grants.
        rq[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = 8'd10; rwd[0] = 128'd1;
        rq[1] = 1'b1; rwe[1] = 1'b1; raddr[1] = 8'd11; rwd[1] = 128'd2;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ctrl", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_we, mem_re}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", {p0_rdata, p1_rdata} == 256'd0, 1);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("cont_gnt", {p1_gnt, p0_gnt}, (c % 2 == 0) ? 2'b01 : 2'b10);
            chk("cont_mem_we", mem_we, 1);
            chk("cont_mem_addr", mem_addr, (c % 2 == 0) ? 10 : 11);
            chk("cont_no_resp", {p0_rvalid, p1_rvalid, p0_err, p1_err}, 0);
        end
        rq[0] = 1'b0; rq[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("cont_mem10", mem[10], 1);
        chk("cont_mem11", mem[11], 2);
        chk("cont_idle", {p0_gnt, p1_gnt, mem_we, mem_re}, 0);

        pre_en = 1'b1; pre_addr = 8'd5; pre_data = 128'hA5;
        @(negedge clk);
        pre_en = 1'b0;

        for (int i = 0; i < 11; i++) access(tbl[i]);

        // Reset landing in the BUSY cycle of a write.
        @(negedge clk);
        rq[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = 8'd3; rwd[0] = 128'h1234;
        begin
            int lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!p0_gnt && lat < 4);
            chk("rstw_gnt_seen", p0_gnt, 1);
        end
        rq[0] = 1'b0;
        rst = 1'b0;
        #1;
        chk("rstw_mem_we", mem_we, 0);
        @(negedge clk);
        chk("rstw_no_resp0", {p0_rvalid, p0_err, p1_rvalid, p1_err}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_no_resp1", {p0_rvalid, p0_err, p1_rvalid, p1_err, p0_gnt, p1_gnt}, 0);
        chk("rstw_mem3", mem[3], 0);
        chk("rstw_rdata", p0_rdata, 0);

        // Randomized run from a fresh reset.
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m_busy = 1'b0; m_port = 0; m_last = 1; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        for (int p = 0; p < 2; p++) begin
            m_rv[p] = 1'b0; m_err[p] = 1'b0; m_rdata[p] = '0;
        end
        for (int a = 0; a < 129; a++) ref_mem[a] = '0;
        rst = 1'b1;
        for (int i = 0; i < 600; i++) begin
            bit g [2];
            bit hit;
            bit n_rv [2];
            bit n_err [2];
            int winner;
            g[0] = m_busy && (m_port == 0);
            g[1] = m_busy && (m_port == 1);
            hit  = (m_addr < 8'd129);
            chk("rnd_gnt", {p1_gnt, p0_gnt}, {g[1], g[0]});
            chk("rnd_mem_we", mem_we, m_busy && hit && m_we);
            chk("rnd_mem_re", mem_re, m_busy && hit && !m_we);
            chk("rnd_mem_addr", mem_addr, {120'd0, m_addr});
            chk("rnd_mem_wdata", mem_wdata, m_wdata);
            chk("rnd_rvalid", {p1_rvalid, p0_rvalid}, {m_rv[1], m_rv[0]});
            chk("rnd_err", {p1_err, p0_err}, {m_err[1], m_err[0]});
            chk("rnd_rdata0", p0_rdata, m_rdata[0]);
            chk("rnd_rdata1", p1_rdata, m_rdata[1]);

            for (int p = 0; p < 2; p++) begin
                if (!rq[p] || g[p]) begin
                    int r;
                    rq[p]  = ($urandom_range(0, 99) < 60);
                    rwe[p] = 1'($urandom_range(0, 1));
                    r = $urandom_range(0, 9);
                    if (r == 0)     raddr[p] = 8'($urandom_range(129, 255));
                    else if (r < 5) raddr[p] = 8'($urandom_range(0, 7));
                    else            raddr[p] = 8'($urandom_range(120, 128));
                    rwd[p] = {$urandom, $urandom, $urandom, $urandom};
                end
            end

            n_rv[0] = 1'b0; n_rv[1] = 1'b0; n_err[0] = 1'b0; n_err[1] = 1'b0;
            if (m_busy) begin
                if (!hit) n_err[m_port] = 1'b1;
                else if (m_we) ref_mem[m_addr] = m_wdata;
                else begin
                    n_rv[m_port] = 1'b1;
                    m_rdata[m_port] = ref_mem[m_addr];
                end
            end
            m_rv = n_rv;
            m_err = n_err;

            winner = -1;
            for (int k = 0; k < 2; k++) begin
                int p;
                p = (m_last + 1 + k) % 2;
                if (winner < 0 && rq[p] && !g[p]) winner = p;
            end
            if (winner >= 0) begin
                m_busy = 1'b1; m_port = winner; m_last = winner;
                m_we = rwe[winner]; m_addr = raddr[winner]; m_wdata = rwd[winner];
            end else begin
                m_busy = 1'b0;
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
